fx2fp_arbiter: RTL and testbench



---
 rtl/fx2fp_pkg.sv | 24 ++
 rtl/fx2fp_core.sv | 38 +++
 rtl/fx2fp_arbiter.sv | 125 ++++++++++++
 tb/tb_fx2fp_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx2fp_pkg.sv
// Shared types and constants for the fixed-point to float arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: fx/fp field widths, exponent bias, fp32_t result layout, FSM state enum.
package fx2fp_pkg;

  localparam int FP_BIAS   = 127;
  localparam int FX_FRAC_W = 8;
  localparam int FX_INT_W  = 8;

  // IEEE-754 single precision, MSB first: {sign, exp, mant}
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/fx2fp_core.sv
// Converts an unsigned 8.8 magnitude plus sign into an IEEE-754 single.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
// Ports: i_int/i_frac = 8.8 magnitude, i_sign = sign, o_fp = packed fp32_t result.
module fx2fp_core
  import fx2fp_pkg::*;
(
  input  logic [FX_INT_W-1:0]  i_int,
  input  logic [FX_FRAC_W-1:0] i_frac,
  input  logic                 i_sign,
  output fp32_t                o_fp
);

  logic [15:0] w_m;
  logic [3:0]  w_p;
  logic        w_nz;
  logic [38:0] w_sh;

  always_comb begin
    w_m  = {i_int, i_frac};
    w_nz = |w_m;
    // Highest set bit wins because later iterations overwrite earlier ones.
    w_p  = 4'd0;
    for (int b = 0; b < 16; b++) begin
      if (w_m[b]) w_p = b[3:0];
    end
    // Move the leading one to bit 23; bits below it become the mantissa.
    // 16 data bits shifted by up to 23 needs 39 bits, so nothing is lost.
    w_sh = {23'd0, w_m} << (5'd23 - {1'b0, w_p});
    o_fp = '0;
    if (w_nz) begin
      o_fp.sign = i_sign;
      o_fp.exp  = 8'(FP_BIAS - FX_FRAC_W) + {4'd0, w_p};
      o_fp.mant = w_sh[22:0];
    end
  end

endmodule

// File: rtl/fx2fp_arbiter.sv
// Round-robin shares one 8.8+sign to fp32 converter among NUM_REQ requesters.
// Latency: out_valid rises on the edge after the accept edge; accepts are at least 3 cycles apart.
// Backpressure: result held on out_* until out_ready; no new grant until it is taken.
// Ports: req_valid/req_ready/req_int/req_frac/req_sign per requester (8-bit lanes packed LSB first),
//        out_valid/out_ready/out_data/out_id result port; done_cnt only when FX2FP_PERF_CNT_EN is defined.
// Build option: FX2FP_PERF_CNT_EN adds a saturating 16-bit completed-result counter.
module fx2fp_arbiter
  import fx2fp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_int,
  input  logic [8*NUM_REQ-1:0] req_frac,
  input  logic [NUM_REQ-1:0]   req_sign,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic [ID_W-1:0]      out_id
`ifdef FX2FP_PERF_CNT_EN
  ,
  output logic [15:0]          done_cnt
`endif
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [FX_INT_W-1:0]   r_int;
  logic [FX_FRAC_W-1:0]  r_frac;
  logic                  r_sign;
  logic [ID_W-1:0]       r_id;

  logic                  w_grant_vld;
  logic [ID_W-1:0]       w_grant_id;
  logic                  w_accept;
  fp32_t                 w_fp;

  // Round-robin search starting at r_rr_ptr. Walking the offsets from the
  // far end down to zero lets the nearest requester overwrite the result.
  always_comb begin : grant_search
    int idx;
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    idx         = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_vld) begin
          req_ready   = NUM_REQ'(1) << w_grant_id;
          w_accept    = 1'b1;
          w_state_nxt = CONV;
        end
      end
      CONV: w_state_nxt = HOLD;
      HOLD: if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  fx2fp_core u_core (
    .i_int  (r_int),
    .i_frac (r_frac),
    .i_sign (r_sign),
    .o_fp   (w_fp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_int     <= '0;
      r_frac    <= '0;
      r_sign    <= 1'b0;
      r_id      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_int    <= req_int[8*w_grant_id +: 8];
        r_frac   <= req_frac[8*w_grant_id +: 8];
        r_sign   <= req_sign[w_grant_id];
        r_id     <= w_grant_id;
        r_rr_ptr <= (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;
      end
      if (r_state == CONV) begin
        out_data  <= w_fp;
        out_id    <= r_id;
        out_valid <= 1'b1;
      end
      if (r_state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef FX2FP_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= '0;
    end else if (out_valid && out_ready && done_cnt != 16'hFFFF) begin
      done_cnt <= done_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fx2fp_arbiter.sv
module tb_fx2fp_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [8*NUM_REQ-1:0] req_int;
  logic [8*NUM_REQ-1:0] req_frac;
  logic [NUM_REQ-1:0]   req_sign;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_data;
  logic [ID_W-1:0]      out_id;
`ifdef FX2FP_PERF_CNT_EN
  logic [15:0]          done_cnt;
`endif

  fx2fp_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_int   (req_int),
    .req_frac  (req_frac),
    .req_sign  (req_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
`ifdef FX2FP_PERF_CNT_EN
    ,
    .done_cnt  (done_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total_cnt = 0;
  int   pass_cnt  = 0;
  int   fail_cnt  = 0;
  int   pops      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard consumer: every accepted result must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out", out_data, 32'hDEAD_BEEF);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", out_data, mon_e.data);
        check("out_id", {30'd0, out_id}, {30'd0, mon_e.id});
      end
      pops++;
    end
  end

  task automatic send(input int id, input logic [7:0] vi, input logic [7:0] vf,
                      input logic vs, input logic [31:0] expd, input bit keep);
    int n;
    n = 0;
    @(posedge clk); #1;
    req_int[8*id +: 8]  = vi;
    req_frac[8*id +: 8] = vf;
    req_sign[id]        = vs;
    req_valid[id]       = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready[id] !== 1'b1 && n < 50);
    check("grant_wait", {31'd0, req_ready[id]}, 32'd1);
    if (keep && req_ready[id] === 1'b1) sb.push_back('{id: ID_W'(id), data: expd});
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[5];
    int got;
    int last_cyc;
    int k;
    int n;

    rst_n     = 1'b0;
    req_valid = '0;
    req_int   = '0;
    req_frac  = '0;
    req_sign  = '0;
    out_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_id", {30'd0, out_id}, 32'd0);
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
`ifdef FX2FP_PERF_CNT_EN
    check("rst_done_cnt", {16'd0, done_cnt}, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 10.625 -> 1.328125 * 2^3; out_valid rises on the edge after accept.
    send(0, 8'h0A, 8'hA0, 1'b0, 32'h412A0000, 1'b1);
    @(negedge clk);
    check("lat_conv_low", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_valid_high", {31'd0, out_valid}, 32'd1);
    drain();

    send(1, 8'h00, 8'h00, 1'b1, 32'h00000000, 1'b1);   // zero ignores sign
    send(2, 8'h00, 8'h01, 1'b0, 32'h3B800000, 1'b1);   // 2^-8
    send(0, 8'h01, 8'h00, 1'b0, 32'h3F800000, 1'b1);   // 1.0
    // 255.99609375 = (65535/32768) * 2^7 -> mant 0x7FFF00
    send(3, 8'hFF, 8'hFF, 1'b1, 32'hC37FFF00, 1'b1);
    drain();

    // All requesters busy: pointer sits at 0 after granting 3.
    order = '{0, 1, 2, 3, 0};
    @(posedge clk); #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_int[8*i +: 8]  = 8'(i + 1);
      req_frac[8*i +: 8] = 8'h00;
      req_sign[i]        = 1'b0;
    end
    req_valid = '1;
    got      = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      @(negedge clk);
      if (req_ready !== 4'b0000) begin
        k = -1;
        for (int j = 0; j < NUM_REQ; j++) if (req_ready[j] === 1'b1) k = j;
        check("rr_onehot", {31'd0, $onehot(req_ready)}, 32'd1);
        check("rr_order", 32'(k), 32'(order[got]));
        if (got > 0) check("rr_spacing", 32'(cyc - last_cyc), 32'd3);
        case (got)
          0: sb.push_back('{id: 2'd0, data: 32'h3F800000});
          1: sb.push_back('{id: 2'd1, data: 32'h40000000});
          2: sb.push_back('{id: 2'd2, data: 32'h40400000});
          3: sb.push_back('{id: 2'd3, data: 32'h40800000});
          default: sb.push_back('{id: 2'd0, data: 32'h40A00000});
        endcase
        last_cyc = cyc;
        got++;
      end
      @(posedge clk); #1;
      if (got == 1) req_int[7:0] = 8'h05;
      if (got == 5) req_valid = '0;
    end
    check("rr_accepts", 32'(got), 32'd5);
    drain();

    // Output stall: result must stay put and no grant may happen.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(2, 8'h00, 8'h01, 1'b0, 32'h3B800000, 1'b1);
    req_int[15:8]  = 8'h01;
    req_frac[15:8] = 8'h00;
    req_sign[1]    = 1'b0;
    req_valid[1]   = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_valid !== 1'b1 && n < 20);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("hold_data", out_data, 32'h3B800000);
      check("hold_id", {30'd0, out_id}, 32'd2);
      check("hold_ready", {28'd0, req_ready}, 32'd0);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);                     // handshake observed by the scoreboard here
    @(negedge clk);
    check("release_valid_low", {31'd0, out_valid}, 32'd0);
    check("release_grant", {28'd0, req_ready}, 32'h2);
    if (req_ready[1] === 1'b1) sb.push_back('{id: 2'd1, data: 32'h3F800000});
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    drain();

    // Reset during CONV; requester 1 leaves the pointer at 2 beforehand.
    send(1, 8'h02, 8'h00, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    check("midrst_out_id", {30'd0, out_id}, 32'd0);
    check("midrst_req_ready", {28'd0, req_ready}, 32'd0);
`ifdef FX2FP_PERF_CNT_EN
    check("midrst_done_cnt", {16'd0, done_cnt}, 32'd0);
`endif
    pops = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_int[7:0]   = 8'h02;
    req_frac[7:0]  = 8'h00;
    req_sign[0]    = 1'b0;
    req_int[23:16] = 8'h03;
    req_frac[23:16] = 8'h00;
    req_sign[2]    = 1'b0;
    req_valid      = 4'b0101;
    @(negedge clk);
    check("postrst_grant0", {28'd0, req_ready}, 32'h1);
    check("postrst_no_stale", {31'd0, out_valid}, 32'd0);
    if (req_ready[0] === 1'b1) sb.push_back('{id: 2'd0, data: 32'h40000000});
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready[2] !== 1'b1 && n < 20);
    check("postrst_grant2", {31'd0, req_ready[2]}, 32'd1);
    if (req_ready[2] === 1'b1) sb.push_back('{id: 2'd2, data: 32'h40400000});
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    drain();
    repeat (3) @(negedge clk);
`ifdef FX2FP_PERF_CNT_EN
    check("done_cnt", {16'd0, done_cnt}, 32'(pops));
`endif
    check("final_idle", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
